// File: rtl/data_memory_ctrl_pkg.sv
// data_memory_ctrl_pkg
//   Shared definitions for the data memory controller: access size codes,
//   controller state encoding and the lane-steering / load-extension helpers
//   used by the top level.
package data_memory_ctrl_pkg;

  // Access size codes carried on req_size.
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Controller states: accept, count down the access latency, report.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } ctrlState_e;

  // Write strobe per lane; lane n holds the byte at word offset n, which is
  // bits 31-8n..24-8n of the big-endian word.
  function automatic logic [3:0] laneStrobe(input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [3:0] strobe;
    case (size)
      SZ_BYTE: strobe = 4'b0001 << offset;
      SZ_HALF: strobe = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

  // Pick the addressed byte/half out of the big-endian word and extend it.
  function automatic logic [31:0] loadExtract(input logic [1:0]  size,
                                              input logic        isSigned,
                                              input logic [1:0]  offset,
                                              input logic [31:0] word);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    case (offset)
      2'b00:   byteVal = word[31:24];
      2'b01:   byteVal = word[23:16];
      2'b10:   byteVal = word[15:8];
      2'b11:   byteVal = word[7:0];
      default: byteVal = 8'h00;
    endcase
    halfVal = offset[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: result = isSigned ? {{24{byteVal[7]}}, byteVal} : {24'h000000, byteVal};
      SZ_HALF: result = isSigned ? {{16{halfVal[15]}}, halfVal} : {16'h0000, halfVal};
      SZ_WORD: result = word;
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if
//   Request/response bus between the datapath (master) and the data memory
//   controller (slave).
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_signed           load extension select
//   req_addr/req_wdata   byte address and store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata/resp_err  load result (held) and error flag
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl_byte_array.sv
// data_memory_ctrl_byte_array
//   2**ADDR_W x 8 byte storage organised as four byte lanes behind a
//   word-aligned index. Lane n is the byte at word offset n (big-endian:
//   lane 0 drives rdData[31:24]). Contents are never reset.
//   clk       rising-edge clock
//   wordIdx   word index (byte address bits ADDR_W-1:2)
//   wrStrobe  per-lane write enable, bit n = lane n
//   wrData    lane-steered store data, lane n on bits 31-8n..24-8n
//   rdData    asynchronous read of the indexed word
module data_memory_ctrl_byte_array #(
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] wordIdx,
  input  logic [3:0]        wrStrobe,
  input  logic [31:0]       wrData,
  output logic [31:0]       rdData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  // Lane writes; only strobed lanes change.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (wrStrobe[lane]) begin
        mem[{wordIdx, 2'(lane)}] <= wrData[31-8*lane -: 8];
      end
    end
  end

  // Word read, lane 0 in the most significant byte.
  always_comb begin
    rdData = {mem[{wordIdx, 2'd0}], mem[{wordIdx, 2'd1}],
              mem[{wordIdx, 2'd2}], mem[{wordIdx, 2'd3}]};
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressed data memory for the multi-cycle MIPS datapath with
//   byte/half/word access, sign/zero extension, error reporting and a
//   configurable access latency.
//   clk   rising-edge clock
//   rst   asynchronous reset, active high (array contents are kept)
//   bus   request/response interface (slave side)
//   Timing: a request accepted at edge k is performed at edge k+LATENCY,
//   and resp_valid is high for the cycle that follows that edge.
module data_memory_ctrl #(
  parameter int    ADDR_W    = 16,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input logic                clk,
  input logic                rst,
  data_memory_ctrl_if.slave  bus
);

  import data_memory_ctrl_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  ctrlState_e  state;
  logic [3:0]  cnt;
  logic        latchWe;
  logic [1:0]  latchSize;
  logic        latchSigned;
  logic [31:0] latchAddr;
  logic [31:0] latchWdata;

  logic        reqReady;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;

  logic        misaligned;
  logic        outOfRange;
  logic        accessErr;
  logic        accessEdge;
  logic [3:0]  wrStrobe;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic [31:0] loadResult;

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

  // Alignment, size and range check on the latched request.
  always_comb begin
    misaligned = 1'b0;
    case (latchSize)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = latchAddr[0];
      SZ_WORD: misaligned = (latchAddr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    // Any address bit above the implemented range is an error; no wrapping.
    outOfRange = ((latchAddr >> ADDR_W) != 32'h0000_0000);
    accessErr  = misaligned || outOfRange;
  end

  // The access happens on the edge that ends the last BUSY cycle.
  always_comb begin
    accessEdge = (state == S_BUSY) && (cnt == 4'd0);
  end

  // Store lane steering; byte/half data is replicated so every lane sees it.
  always_comb begin
    wrData = latchWdata;
    case (latchSize)
      SZ_BYTE: wrData = {4{latchWdata[7:0]}};
      SZ_HALF: wrData = {2{latchWdata[15:0]}};
      default: wrData = latchWdata;
    endcase
    if (accessEdge && latchWe && !accessErr) begin
      wrStrobe = laneStrobe(latchSize, latchAddr[1:0]);
    end else begin
      wrStrobe = 4'b0000;
    end
  end

  data_memory_ctrl_byte_array #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) uArray (
    .clk      (clk),
    .wordIdx  (latchAddr[ADDR_W-1:2]),
    .wrStrobe (wrStrobe),
    .wrData   (wrData),
    .rdData   (rdData)
  );

  // Load result extraction and extension.
  always_comb begin
    loadResult = loadExtract(latchSize, latchSigned, latchAddr[1:0], rdData);
  end

  // Controller FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      latchWe     <= 1'b0;
      latchSize   <= SZ_BYTE;
      latchSigned <= 1'b0;
      latchAddr   <= 32'h0000_0000;
      latchWdata  <= 32'h0000_0000;
      reqReady    <= 1'b1;
      respValid   <= 1'b0;
      respRdata   <= 32'h0000_0000;
      respErr     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          respValid <= 1'b0;
          if (bus.req_valid) begin
            latchWe     <= bus.req_we;
            latchSize   <= bus.req_size;
            latchSigned <= bus.req_signed;
            latchAddr   <= bus.req_addr;
            latchWdata  <= bus.req_wdata;
            cnt         <= CNT_LOAD;
            reqReady    <= 1'b0;
            state       <= S_BUSY;
          end else begin
            reqReady <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            respValid <= 1'b1;
            respErr   <= accessErr;
            // Stores and failed accesses report zero data.
            respRdata <= (accessErr || latchWe) ? 32'h0000_0000 : loadResult;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          respValid <= 1'b0;
          reqReady  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cnt       <= 4'd0;
          respValid <= 1'b0;
          reqReady  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
//   Drives two controllers (LATENCY=1 and LATENCY=3) with identical traffic
//   and compares both against a byte-level reference model.
module tb_data_memory_ctrl;
  import data_memory_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_memory_ctrl_if ifL1 ();
  data_memory_ctrl_if ifL3 ();

  data_memory_ctrl #(.ADDR_W(16), .LATENCY(1), .INIT_FILE("")) dutL1 (
    .clk (clk), .rst (rst), .bus (ifL1.slave)
  );
  data_memory_ctrl #(.ADDR_W(16), .LATENCY(3), .INIT_FILE("")) dutL3 (
    .clk (clk), .rst (rst), .bus (ifL3.slave)
  );

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expErr;
  } txn_t;

  int passCount = 0;
  int checkCount = 0;
  int expLat [2] = '{1, 3};

  logic [7:0]  refMem [int];
  logic [31:0] obsRdata [2];
  logic        obsErr [2];
  int          obsLat [2];
  logic        sReady [2];
  logic        sValid [2];
  logic [31:0] sRdata [2];
  logic        sErr [2];

  // Reference model: memory as individual bytes, values built arithmetically.
  function automatic logic [32:0] modelAccess(input bit we, input logic [1:0] size, input bit sgn,
                                              input logic [31:0] addr, input logic [31:0] wdata);
    int nb;
    longint val;
    if (size == 2'b11) return {1'b1, 32'h0};
    nb = 1 << size;
    if ((addr % nb) != 0 || addr >= 32'h0001_0000) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < nb; i++)
        refMem[int'(addr) + i] = 8'((wdata >> (8 * (nb - 1 - i))) & 32'hFF);
      return {1'b0, 32'h0};
    end
    val = 0;
    for (int i = 0; i < nb; i++) val = val * 256 + longint'(refMem[int'(addr) + i]);
    if (sgn && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
    return {1'b0, val[31:0]};
  endfunction

  function automatic txn_t mk(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] expRdata, input bit expErr);
    txn_t t;
    t.we = we; t.size = size; t.sgn = sgn; t.addr = addr; t.wdata = wdata;
    t.expRdata = expRdata; t.expErr = expErr;
    return t;
  endfunction

  task automatic setReq(input bit valid, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ifL1.req_valid = valid; ifL1.req_we = we; ifL1.req_size = size;
    ifL1.req_signed = sgn; ifL1.req_addr = addr; ifL1.req_wdata = wdata;
    ifL3.req_valid = valid; ifL3.req_we = we; ifL3.req_size = size;
    ifL3.req_signed = sgn; ifL3.req_addr = addr; ifL3.req_wdata = wdata;
  endtask

  task automatic snap();
    sReady[0] = ifL1.req_ready; sValid[0] = ifL1.resp_valid; sRdata[0] = ifL1.resp_rdata; sErr[0] = ifL1.resp_err;
    sReady[1] = ifL3.req_ready; sValid[1] = ifL3.resp_valid; sRdata[1] = ifL3.resp_rdata; sErr[1] = ifL3.resp_err;
  endtask

  // One request to both DUTs; records data, error and accept-to-response latency.
  task automatic doTxn(input txn_t t);
    bit seen [2];
    @(negedge clk);
    setReq(1'b1, t.we, t.size, t.sgn, t.addr, t.wdata);
    @(posedge clk);
    @(negedge clk);
    setReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      seen[d] = 1'b0; obsLat[d] = -1; obsRdata[d] = 32'hx; obsErr[d] = 1'bx;
    end
    for (int n = 1; n <= 20 && !(seen[0] && seen[1]); n++) begin
      if (n > 1) @(negedge clk);
      snap();
      for (int d = 0; d < 2; d++) begin
        if (!seen[d] && sValid[d]) begin
          seen[d] = 1'b1; obsLat[d] = n - 1; obsRdata[d] = sRdata[d]; obsErr[d] = sErr[d];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    snap();
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (sReady[d] !== 1'b1 || sValid[d] !== 1'b0 || sRdata[d] !== 32'h0 || sErr[d] !== 1'b0)
        $display("FAIL reset L%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                 expLat[d], sReady[d], sValid[d], sRdata[d], sErr[d]);
      else passCount++;
    end
    rst = 1'b0;
  endtask

  task automatic runTable_word(input string name, input txn_t tbl [$]);
    logic [32:0] m;
    foreach (tbl[i]) begin
      doTxn(tbl[i]);
      m = modelAccess(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (obsRdata[d] !== tbl[i].expRdata || obsErr[d] !== tbl[i].expErr || obsLat[d] != expLat[d])
          $display("FAIL %s[%0d] L%0d: rdata=%h err=%b lat=%0d, want %h %b %0d", name, i, expLat[d],
                   obsRdata[d], obsErr[d], obsLat[d], tbl[i].expRdata, tbl[i].expErr, expLat[d]);
        else passCount++;
      end
    end
  endtask

  task automatic test_word_latency();
    txn_t tbl [$];
    tbl.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0));
    runTable_word("word", tbl);
  endtask

  task automatic test_byte();
    txn_t tbl [$];
    tbl.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h0000_0022, 1'b0));
    tbl.push_back(mk(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_0080, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 32'hFFFF_FF80, 1'b0));
    tbl.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 32'h0000_0080, 1'b0));
    tbl.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122_8044, 1'b0));
    runTable_word("byte", tbl);
  endtask

  task automatic test_half();
    txn_t tbl [$];
    tbl.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0));
    tbl.push_back(mk(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0));
    tbl.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0000_BEEF, 1'b0));
    runTable_word("half", tbl);
  endtask

  task automatic test_errors();
    txn_t tbl [$];
    tbl.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000_1234, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, SZ_ILLEGAL, 1'b0, 32'h20, 32'h5555_5555, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0001_0000, 32'hCAFE_F00D, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h0001_FFFF, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0000_BEEF, 1'b0));
    runTable_word("err", tbl);
  endtask

  // With req_valid held, a request is accepted only in IDLE: the accept
  // cycle, LATENCY BUSY cycles and one RESP cycle pass before ready returns,
  // so accepts are LATENCY+2 cycles apart.
  task automatic test_back_to_back();
    int acc [2][$];
    int respCnt [2];
    int period;
    int nCyc = 15;
    respCnt[0] = 0; respCnt[1] = 0;
    @(negedge clk);
    setReq(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < nCyc; c++) begin
      snap();
      for (int d = 0; d < 2; d++) begin
        if (sReady[d]) acc[d].push_back(c);
        if (sValid[d]) respCnt[d]++;
      end
      @(negedge clk);
    end
    setReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      snap();
      for (int d = 0; d < 2; d++) if (sValid[d]) respCnt[d]++;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      period = expLat[d] + 2;
      checkCount++;
      if (acc[d].size() != (nCyc + period - 1) / period)
        $display("FAIL b2b_accepts L%0d: got %0d, want %0d", expLat[d], acc[d].size(), (nCyc + period - 1) / period);
      else passCount++;
      checkCount++;
      if (respCnt[d] != acc[d].size())
        $display("FAIL b2b_resp_pulses L%0d: got %0d, want %0d", expLat[d], respCnt[d], acc[d].size());
      else passCount++;
      for (int i = 1; i < acc[d].size(); i++) begin
        checkCount++;
        if (acc[d][i] - acc[d][i-1] != period)
          $display("FAIL b2b_gap L%0d: got %0d, want %0d", expLat[d], acc[d][i] - acc[d][i-1], period);
        else passCount++;
      end
    end
  endtask

  task automatic test_reset_midbusy();
    txn_t t;
    t = mk(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0102_0304, 32'h0, 1'b0);
    doTxn(t);
    void'(modelAccess(t.we, t.size, t.sgn, t.addr, t.wdata));
    @(negedge clk);
    setReq(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'hDEAD_BEEF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    setReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (sReady[d] !== 1'b1 || sValid[d] !== 1'b0)
        $display("FAIL rst_busy L%0d: ready=%b valid=%b, want 1 0", expLat[d], sReady[d], sValid[d]);
      else passCount++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = mk(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h0102_0304, 1'b0);
    doTxn(t);
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (obsRdata[d] !== 32'h0102_0304 || obsErr[d] !== 1'b0 || obsLat[d] != expLat[d])
        $display("FAIL rst_busy_data L%0d: rdata=%h err=%b lat=%0d, want 01020304 0 %0d",
                 expLat[d], obsRdata[d], obsErr[d], obsLat[d], expLat[d]);
      else passCount++;
    end
  endtask

  task automatic test_random();
    txn_t t;
    logic [32:0] m;
    for (int i = 0; i < 16; i++) begin
      t = mk(1'b1, SZ_WORD, 1'b0, 32'h200 + 32'(4 * i), $urandom, 32'h0, 1'b0);
      doTxn(t);
      void'(modelAccess(t.we, t.size, t.sgn, t.addr, t.wdata));
    end
    for (int i = 0; i < 40; i++) begin
      t.we = 1'($urandom_range(0, 1));
      t.size = 2'($urandom_range(0, 3));
      t.sgn = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      if ($urandom_range(0, 9) == 0) t.addr = 32'h0001_0200 + 32'($urandom_range(0, 63));
      else t.addr = 32'h200 + 32'($urandom_range(0, 63));
      m = modelAccess(t.we, t.size, t.sgn, t.addr, t.wdata);
      doTxn(t);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (obsRdata[d] !== m[31:0] || obsErr[d] !== m[32] || obsLat[d] != expLat[d])
          $display("FAIL rand[%0d] L%0d we=%b sz=%b s=%b a=%h: rdata=%h err=%b lat=%0d, want %h %b %0d",
                   i, expLat[d], t.we, t.size, t.sgn, t.addr, obsRdata[d], obsErr[d], obsLat[d],
                   m[31:0], m[32], expLat[d]);
        else passCount++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_latency();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_midbusy();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
